uart_rx_checker: RTL and testbench
==================================

# uart_rx_checker

Parametrised link-integrity checker for the UART receive path: instantiates `UartRx`, checks that received bytes follow a known pattern (incrementing or 8-bit LFSR), and measures the clock interval between consecutive bytes. Self-synchronises on the first byte, counts data and timing errors in saturating counters, and drops lock on a line timeout. Sits at the top of the FPGA loopback/bring-up build, driving debug LEDs and a readout of counters.

## Interface
- `clockRate`, 76_800_000, system clock frequency in Hz, passed to `UartRx`
- `baudRate`, 12_000_000, UART bit rate, passed to `UartRx`
- `cycleBits`, 12, width of the interval timer and `cycle`
- `countBits`, 16, width of `byteCount`, `dataErrors`, `timingErrors`
- `pattern`, 0, expected sequence: 0 = increment mod 256; 1 = LFSR
- `tolerance`, 0, allowed |interval − cycle| in clocks before a timing error

- `clk` input 1 system clock; one clock domain
- `reset` input 1 synchronous, active-high
- `uart` input 1 serial line into `UartRx`
- `locked` output 1 checker synchronised to the pattern
- `cycle` output cycleBits reference byte interval in clocks; 0 = not yet learned
- `byteCount` output countBits bytes checked while locked, saturating
- `dataErrors` output countBits pattern mismatches, saturating
- `timingErrors` output countBits out-of-tolerance intervals, saturating
- `dataError` output 1 sticky: any data error since reset
- `timingError` output 1 sticky: any timing error since reset

## Operation
- Internal `available` (1-cycle pulse) and `data[7:0]` from `UartRx`.
- next(v): pattern 0 → v+1 mod 256; pattern 1 → {v[6:0], v[7]^v[5]^v[4]^v[3]}, except next(0x00)=0x01.
- States: HUNT, LOCKED.
- HUNT: on `available`: expected ← next(data), timer ← 1, cycle ← 0, → LOCKED. No counters change. Otherwise timer holds.
- LOCKED, `available` with interval = timer:
  - byteCount += 1 (saturate at all-ones).
  - data ≠ expected → dataErrors += 1 (saturate), dataError ← 1. Expected ← next(data) in both cases (resync, one error per corrupt byte, not a burst).
  - cycle = 0 → cycle ← interval, no timing check.
  - cycle ≠ 0 and |interval − cycle| > tolerance → timingErrors += 1 (saturate), timingError ← 1; cycle unchanged (reference fixed until relock).
  - timer ← 1.
- LOCKED, no `available`: timer += 1. When timer reaches all-ones (timeout): → HUNT, cycle ← 0, timer ← 1. Counters and sticky flags retained.
- Difference computed at cycleBits+1 bits, no wrap.
- Reset: state HUNT, timer 1, expected 0x01, all outputs 0 (`locked` 0, `cycle` 0, counters 0, sticky flags 0). Reset wins over a coincident `available`; mid-byte reset discards the byte.

## Timing
- All outputs registered; update on the clock edge after the cycle `available` is high (1-cycle latency).
- `locked` = (state == LOCKED), registered; rises 1 cycle after the first `available`, falls 1 cycle after timeout.
- Interval = clock edges between consecutive `available` pulses (back-to-back at defaults: 64).
- `available` coincident with timeout value: byte processed normally, no unlock.
- Counters saturate; no wrap to 0.

## Test plan
- Defaults, reset, send 0x05..0x0C back-to-back → locked after 0x05, cycle=64, byteCount=7, dataErrors=0, timingErrors=0.
- pattern=0, send 0x10,0x11,0x55,0x56,0x57 → dataErrors=1, dataError=1, byteCount=4 (resync, no further errors).
- Defaults, after lock insert one 20-clock gap → timingErrors=1, cycle stays 64; rerun tolerance=32 → timingErrors=0.
- pattern=1, seed 0x01, send 10-step LFSR sequence, then one bit-flipped byte → dataErrors=1 only.
- Idle line 4095 clocks after lock → locked=0, cycle=0, counters held; next byte relocks, cycle relearned.
- Reset asserted mid-byte with countBits=2 and counters saturated at 3 → all outputs 0 next cycle; partial byte produces no count.

Source files
------------

// File: rtl/uart_rx_checker.sv
// UART link-integrity checker: receives bytes, checks them against an
// incrementing or LFSR pattern and measures the interval between bytes.
// Also contains UartRx, a fractional-rate UART receiver (8N1, LSB first).

module UartRx #(
  parameter int clockRate = 76_800_000,
  parameter int baudRate  = 12_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart,
  output logic       available,
  output logic [7:0] data
);

  // Phase is kept in half-bit units scaled so that one clock = 2*baudRate
  // and one bit = 2*clockRate; this gives exact fractional bit timing.
  localparam logic signed [31:0] HALF_BIT = 32'(clockRate);
  localparam logic signed [31:0] FULL_BIT = 32'(2 * clockRate);
  localparam logic signed [31:0] STEP     = 32'(2 * baudRate);

  typedef enum logic {IDLE, BUSY} rx_state_t;

  rx_state_t          rx_state, rx_next;
  logic               uart_p0, uart_p1, uart_p2;
  logic signed [31:0] phase;
  logic [3:0]         bit_idx;
  logic [7:0]         shift;
  logic               start, tick;

  // uart_p2 is cleared by reset so that a line already low after reset
  // (e.g. in the middle of a frame) is never taken as a start bit.
  assign start = (rx_state == IDLE) && uart_p2 && !uart_p1;
  assign tick  = (rx_state == BUSY) && (phase <= 32'sd0);

  // Two-stage synchroniser for the asynchronous serial line
  always_ff @(posedge clk) begin
    uart_p0 <= uart;
    uart_p1 <= uart_p0;
  end

  // Control state: frame FSM, bit index, edge history and output strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state  <= IDLE;
      uart_p2   <= 1'b0;
      bit_idx   <= 4'd0;
      available <= 1'b0;
    end else begin
      rx_state  <= rx_next;
      uart_p2   <= uart_p1;
      available <= tick && (bit_idx == 4'd9) && uart_p1;
      if (start)
        bit_idx <= 4'd0;
      else if (tick)
        bit_idx <= bit_idx + 4'd1;
    end
  end

  // Frame sequencing: abort on a false start bit, finish after the stop bit
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE: if (start) rx_next = BUSY;
      BUSY: if (tick && ((bit_idx == 4'd0 && uart_p1) || bit_idx == 4'd9))
              rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  // Datapath: mid-bit phase accumulator, shift register and output byte
  always_ff @(posedge clk) begin
    if (start)
      phase <= HALF_BIT - STEP;
    else if (rx_state == BUSY)
      phase <= tick ? (phase + FULL_BIT - STEP) : (phase - STEP);
    if (tick && bit_idx >= 4'd1 && bit_idx <= 4'd8)
      shift <= {uart_p1, shift[7:1]};
    if (tick && bit_idx == 4'd9)
      data <= shift;
  end

endmodule

module uart_rx_checker #(
  parameter int clockRate = 76_800_000,
  parameter int baudRate  = 12_000_000,
  parameter int cycleBits = 12,
  parameter int countBits = 16,
  parameter int pattern   = 0,
  parameter int tolerance = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart,
  output logic                 locked,
  output logic [cycleBits-1:0] cycle,
  output logic [countBits-1:0] byteCount,
  output logic [countBits-1:0] dataErrors,
  output logic [countBits-1:0] timingErrors,
  output logic                 dataError,
  output logic                 timingError
);

  localparam logic [cycleBits:0] TOL = (cycleBits + 1)'(tolerance);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t               state, state_next;
  logic                 available;
  logic [7:0]           data;
  logic [cycleBits-1:0] timer, timer_next, cycle_next;
  logic [7:0]           expected, expected_next;
  logic [countBits-1:0] byte_next, derr_next, terr_next;
  logic                 dflag_next, tflag_next;

  function automatic logic [7:0] next_val(input logic [7:0] v);
    if (pattern == 0)
      return v + 8'd1;
    else if (v == 8'h00)
      return 8'h01;
    else
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [countBits-1:0] sat_inc(input logic [countBits-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // One bit wider than the operands so the difference never wraps
  function automatic logic [cycleBits:0] abs_diff(input logic [cycleBits-1:0] a,
                                                  input logic [cycleBits-1:0] b);
    logic signed [cycleBits:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  UartRx #(
    .clockRate(clockRate),
    .baudRate (baudRate)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .uart     (uart),
    .available(available),
    .data     (data)
  );

  assign locked = (state == LOCKED);

  // State and all outputs registered; reset clears everything to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HUNT;
      timer        <= cycleBits'(1);
      expected     <= 8'h01;
      cycle        <= '0;
      byteCount    <= '0;
      dataErrors   <= '0;
      timingErrors <= '0;
      dataError    <= 1'b0;
      timingError  <= 1'b0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      expected     <= expected_next;
      cycle        <= cycle_next;
      byteCount    <= byte_next;
      dataErrors   <= derr_next;
      timingErrors <= terr_next;
      dataError    <= dflag_next;
      timingError  <= tflag_next;
    end
  end

  // Lock/hunt sequencing, pattern and interval checks, line timeout
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    expected_next = expected;
    cycle_next    = cycle;
    byte_next     = byteCount;
    derr_next     = dataErrors;
    terr_next     = timingErrors;
    dflag_next    = dataError;
    tflag_next    = timingError;
    case (state)
      HUNT: begin
        if (available) begin
          state_next    = LOCKED;
          expected_next = next_val(data);
          timer_next    = cycleBits'(1);
          cycle_next    = '0;
        end
      end
      LOCKED: begin
        if (available) begin
          byte_next     = sat_inc(byteCount);
          expected_next = next_val(data);
          if (data != expected) begin
            derr_next  = sat_inc(dataErrors);
            dflag_next = 1'b1;
          end
          if (cycle == '0) begin
            cycle_next = timer;
          end else if (abs_diff(timer, cycle) > TOL) begin
            terr_next  = sat_inc(timingErrors);
            tflag_next = 1'b1;
          end
          timer_next = cycleBits'(1);
        end else if (timer == '1) begin
          state_next = HUNT;
          cycle_next = '0;
          timer_next = cycleBits'(1);
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: state_next = HUNT;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_checker.sv
// Scoreboard bench for uart_rx_checker: two instances (incrementing pattern
// with zero tolerance; LFSR pattern with tolerance 32 and 2-bit counters).
module tb_uart_rx_checker;

  localparam longint CLK_RATE = 76_800_000;
  localparam longint BAUD     = 12_000_000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_a = 1'b1, uart_b = 1'b1;

  logic        locked_a, def_a, tef_a;
  logic [11:0] cycle_a;
  logic [15:0] bc_a, de_a, te_a;
  logic        locked_b, def_b, tef_b;
  logic [11:0] cycle_b;
  logic [1:0]  bc_b, de_b, te_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  uart_rx_checker #(.pattern(0), .tolerance(0)) dut_a (
    .clk(clk), .reset(reset), .uart(uart_a), .locked(locked_a), .cycle(cycle_a),
    .byteCount(bc_a), .dataErrors(de_a), .timingErrors(te_a),
    .dataError(def_a), .timingError(tef_a));

  uart_rx_checker #(.pattern(1), .tolerance(32), .countBits(2)) dut_b (
    .clk(clk), .reset(reset), .uart(uart_b), .locked(locked_b), .cycle(cycle_b),
    .byteCount(bc_b), .dataErrors(de_b), .timingErrors(te_b),
    .dataError(def_b), .timingError(tef_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural reference: per-instance lock state, expected byte, counters
  typedef struct { bit lk; int cy; int bc; int de; int te; bit df; bit tf; } exp_t;
  int  m_pat [2] = '{0, 1};
  int  m_tol [2] = '{0, 32};
  int  m_max [2] = '{65535, 3};
  bit  m_lock[2];
  int  m_cyc [2], m_exp[2], m_bc[2], m_de[2], m_te[2], m_last[2];
  bit  m_df  [2], m_tf[2];
  exp_t q_a[$], q_b[$];

  function automatic int nxt(input int i, input int v);
    if (m_pat[i] == 0) return (v + 1) % 256;
    if (v == 0) return 1;
    return ((v * 2) % 256) + (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
  endfunction

  function automatic int sat(input int i, input int v);
    return (v >= m_max[i]) ? m_max[i] : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lock[i] = 0; m_cyc[i] = 0; m_exp[i] = 1; m_bc[i] = 0; m_de[i] = 0;
      m_te[i] = 0; m_df[i] = 0; m_tf[i] = 0; m_last[i] = 0;
    end
  endtask

  task automatic model_byte(input int i, input int b, input int s);
    int iv, d;
    exp_t e;
    iv = s - m_last[i];
    if (m_lock[i] && iv > 4095) begin
      m_lock[i] = 0; m_cyc[i] = 0;
    end
    if (!m_lock[i]) begin
      m_lock[i] = 1; m_cyc[i] = 0;
    end else begin
      m_bc[i] = sat(i, m_bc[i]);
      if (b != m_exp[i]) begin m_de[i] = sat(i, m_de[i]); m_df[i] = 1; end
      if (m_cyc[i] == 0) m_cyc[i] = iv;
      else begin
        d = (iv > m_cyc[i]) ? iv - m_cyc[i] : m_cyc[i] - iv;
        if (d > m_tol[i]) begin m_te[i] = sat(i, m_te[i]); m_tf[i] = 1; end
      end
    end
    m_exp[i]  = nxt(i, b);
    m_last[i] = s;
    e = '{m_lock[i], m_cyc[i], m_bc[i], m_de[i], m_te[i], m_df[i], m_tf[i]};
    if (i == 0) q_a.push_back(e); else q_b.push_back(e);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input longint lk, input longint cy,
                     input longint bc, input longint de, input longint te,
                     input longint df, input longint tf);
    chk({tag, ".locked"}, lk, e.lk);
    chk({tag, ".cycle"}, cy, e.cy);
    chk({tag, ".byteCount"}, bc, e.bc);
    chk({tag, ".dataErrors"}, de, e.de);
    chk({tag, ".timingErrors"}, te, e.te);
    chk({tag, ".dataError"}, df, e.df);
    chk({tag, ".timingError"}, tf, e.tf);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int i, input logic v);
    if (i == 0) uart_a = v; else uart_b = v;
  endtask

  // Drives one 8N1 frame; bit k starts floor(k*clock/baud) clocks after the start
  task automatic send_bits(input int i, input int b);
    longint e0, e1;
    int v;
    for (int k = 0; k < 10; k++) begin
      v = (k == 0) ? 0 : (k == 9) ? 1 : ((b >> (k - 1)) & 1);
      set_line(i, v[0]);
      e0 = (longint'(k) * CLK_RATE) / BAUD;
      e1 = (longint'(k + 1) * CLK_RATE) / BAUD;
      wait_cycles(int'(e1 - e0));
    end
    set_line(i, 1'b1);
  endtask

  task automatic send_byte(input int i, input int b);
    model_byte(i, b, cyc);
    send_bits(i, b);
  endtask

  task automatic do_reset();
    wait_cycles(10);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    model_reset();
    wait_cycles(5);
  endtask

  // Monitor: each received byte must match the head of that instance's queue
  initial begin : monitor
    bit pa, pb;
    exp_t e;
    pa = 0; pb = 0;
    forever begin
      @(negedge clk);
      if (pa) begin
        if (q_a.size() == 0) chk("a.unexpected_byte", 1, 0);
        else begin
          e = q_a.pop_front();
          cmp("a", e, locked_a, cycle_a, bc_a, de_a, te_a, def_a, tef_a);
        end
      end
      if (pb) begin
        if (q_b.size() == 0) chk("b.unexpected_byte", 1, 0);
        else begin
          e = q_b.pop_front();
          cmp("b", e, locked_b, cycle_b, bc_b, de_b, te_b, def_b, tef_b);
        end
      end
      pa = dut_a.available;
      pb = dut_b.available;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int v, gap, b;
    model_reset();
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(1);
    chk("reset.locked", locked_a, 0);
    chk("reset.cycle", cycle_a, 0);
    chk("reset.byteCount", bc_a, 0);
    wait_cycles(5);

    // Back-to-back incrementing bytes
    for (int k = 5; k <= 12; k++) send_byte(0, k);
    wait_cycles(10);
    chk("b2b.locked", locked_a, 1);
    chk("b2b.cycle", cycle_a, 64);
    chk("b2b.byteCount", bc_a, 7);
    chk("b2b.dataErrors", de_a, 0);
    chk("b2b.timingErrors", te_a, 0);

    // One corrupt byte resyncs with a single error
    do_reset();
    send_byte(0, 8'h10); send_byte(0, 8'h11); send_byte(0, 8'h55);
    send_byte(0, 8'h56); send_byte(0, 8'h57);
    wait_cycles(10);
    chk("corrupt.dataErrors", de_a, 1);
    chk("corrupt.dataError", def_a, 1);
    chk("corrupt.byteCount", bc_a, 4);

    // 20-clock gap: error at tolerance 0, none at tolerance 32
    do_reset();
    for (int k = 32; k < 38; k++) send_byte(0, k);
    wait_cycles(20);
    send_byte(0, 38); send_byte(0, 39);
    v = 1;
    for (int k = 0; k < 11; k++) begin
      if (k == 5) wait_cycles(20);
      send_byte(1, v);
      v = nxt(1, v);
    end
    send_byte(1, v ^ 8'h10);
    send_byte(1, nxt(1, v ^ 8'h10));
    wait_cycles(10);
    chk("gap.timingErrors_tol0", te_a, 1);
    chk("gap.cycle_tol0", cycle_a, 64);
    chk("gap.timingErrors_tol32", te_b, 0);
    chk("lfsr.dataErrors", de_b, 1);
    chk("lfsr.byteCount_sat", bc_b, 3);

    // Line timeout drops lock but keeps counters; next bytes relearn
    wait_cycles(3000);
    chk("idle.still_locked", locked_a, 1);
    wait_cycles(1300);
    chk("idle.locked", locked_a, 0);
    chk("idle.cycle", cycle_a, 0);
    chk("idle.byteCount", bc_a, m_bc[0]);
    chk("idle.timingErrors", te_a, m_te[0]);
    send_byte(0, 8'h80); send_byte(0, 8'h81);
    wait_cycles(10);
    chk("relock.cycle", cycle_a, 64);
    // Interval exactly at the timeout value stays locked; one more unlocks
    wait_cycles(4031 - 10);
    send_byte(0, 8'h82);
    wait_cycles(4032);
    send_byte(0, 8'h83);
    send_byte(0, 8'h84);

    // Randomised traffic on both instances
    for (int i = 0; i < 2; i++) begin
      do_reset();
      for (int n = 0; n < 50; n++) begin
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (i == 0) ? 40 : 90) : 0;
        if (gap > 0) wait_cycles(gap);
        b = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : m_exp[i];
        send_byte(i, b);
      end
    end
    wait_cycles(10);
    chk("rand.byteCount_b", bc_b, m_bc[1]);
    chk("rand.dataErrors_b", de_b, m_de[1]);

    // Reset in the middle of a frame clears outputs and discards the byte
    fork
      send_bits(1, 8'hF0);
      begin
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        model_reset();
        chk("midreset.locked", locked_b, 0);
        chk("midreset.cycle", cycle_b, 0);
        chk("midreset.byteCount", bc_b, 0);
        chk("midreset.dataErrors", de_b, 0);
        chk("midreset.timingErrors", te_b, 0);
        chk("midreset.dataError", def_b, 0);
        chk("midreset.timingError", tef_b, 0);
      end
    join
    wait_cycles(80);
    chk("midreset.after_locked", locked_b, 0);
    chk("midreset.after_byteCount", bc_b, 0);

    wait_cycles(20);
    chk("queue_a.drained", q_a.size(), 0);
    chk("queue_b.drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
